// File: rtl/fft_frame_src.sv
// fft_frame_src: streams N-point complex frames from a one-port synchronous
// sample SRAM onto a valid/ready stream, running a programmable number of
// back-to-back frames per start command.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start_i; latches base address and frame count
// S_FETCH | issuing SRAM reads while fewer than 2 samples are in flight/buffered
// S_DRAIN | all reads issued; waiting for the buffer to empty after the last beat
// S_DONE  | one-cycle done_o pulse, then back to S_IDLE
module fft_frame_src #(
    parameter int DATA_W = 16,
    parameter int LOGN   = 10,
    parameter int ADDR_W = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [7:0]          num_frames_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [7:0]          frame_cnt_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic [2*DATA_W-1:0] mem_rdata_i,
    output logic                valid_o,
    output logic [2*DATA_W-1:0] data_o,
    output logic                last_o,
    input  logic                ready_i
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

    localparam logic [LOGN-1:0] IDX_LAST = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          nfr_q, nfr_d;
    logic [7:0]          frame_q, frame_d;
    logic [7:0]          fcnt_q, fcnt_d;
    logic [LOGN-1:0]     idx_q, idx_d;
    logic                infl_q, infl_d;
    logic                infl_last_q, infl_last_d;
    logic                out_v_q, out_v_d;
    logic                out_last_q, out_last_d;
    logic [2*DATA_W-1:0] out_data_q, out_data_d;
    logic                spare_v_q, spare_v_d;
    logic                spare_last_q, spare_last_d;
    logic [2*DATA_W-1:0] spare_data_q, spare_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pop;
    logic                req;
    logic [2:0]          used;

    // Next-state logic: sequencing, read issue and the 2-entry output buffer.
    // The buffer is the output register (head) plus one spare entry behind it.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        nfr_d        = nfr_q;
        frame_d      = frame_q;
        fcnt_d       = fcnt_q;
        idx_d        = idx_q;
        out_v_d      = out_v_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        spare_v_d    = spare_v_q;
        spare_last_d = spare_last_q;
        spare_data_d = spare_data_q;

        pop  = out_v_q & ready_i;
        used = 3'(out_v_q) + 3'(spare_v_q) + 3'(infl_q);
        req  = (state_q == S_FETCH) && (used < (3'd2 + 3'(pop)));

        infl_d      = req;
        infl_last_d = req && (idx_q == IDX_LAST);

        if (pop && out_last_q) begin
            fcnt_d = fcnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = base_addr_i;
                    nfr_d   = num_frames_i;
                    frame_d = 8'd0;
                    idx_d   = '0;
                    fcnt_d  = 8'd0;
                    state_d = (num_frames_i == 8'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (req) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        frame_d = frame_q + 8'd1;
                        if (frame_q == nfr_q - 8'd1) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        idx_d = idx_q + LOGN'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!infl_q && !spare_v_q && (!out_v_q || pop)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Head refills from the spare entry first so sample order is kept.
        if (pop || !out_v_q) begin
            if (spare_v_q) begin
                out_v_d      = 1'b1;
                out_data_d   = spare_data_q;
                out_last_d   = spare_last_q;
                spare_v_d    = infl_q;
                spare_data_d = mem_rdata_i;
                spare_last_d = infl_last_q;
            end else begin
                out_v_d    = infl_q;
                out_data_d = mem_rdata_i;
                out_last_d = infl_last_q;
            end
        end else if (infl_q) begin
            spare_v_d    = 1'b1;
            spare_data_d = mem_rdata_i;
            spare_last_d = infl_last_q;
        end

        busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State register; a synchronous reset also drops any read still in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            nfr_q        <= 8'd0;
            frame_q      <= 8'd0;
            fcnt_q       <= 8'd0;
            idx_q        <= '0;
            infl_q       <= 1'b0;
            infl_last_q  <= 1'b0;
            out_v_q      <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            spare_v_q    <= 1'b0;
            spare_last_q <= 1'b0;
            spare_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            nfr_q        <= nfr_d;
            frame_q      <= frame_d;
            fcnt_q       <= fcnt_d;
            idx_q        <= idx_d;
            infl_q       <= infl_d;
            infl_last_q  <= infl_last_d;
            out_v_q      <= out_v_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            spare_v_q    <= spare_v_d;
            spare_last_q <= spare_last_d;
            spare_data_q <= spare_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign frame_cnt_o = fcnt_q;
    assign mem_req_o   = req;
    assign mem_addr_o  = addr_q;
    assign valid_o     = out_v_q;
    assign data_o      = out_data_q;
    assign last_o      = out_last_q;

endmodule

// File: tb/tb_fft_frame_src.sv
// tb_fft_frame_src: directed bench for fft_frame_src with LOGN=3, one instance
// with a 12-bit address space and one with a 4-bit space for wrap-around.
module tb_fft_frame_src;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [7:0]  nfr;
    logic        busy, done, mem_req, valid, last, ready;
    logic [7:0]  frame_cnt;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata, data;

    logic        b_start;
    logic [3:0]  b_base_addr;
    logic [7:0]  b_nfr;
    logic        b_busy, b_done, b_mem_req, b_valid, b_last, b_ready;
    logic [7:0]  b_frame_cnt;
    logic [3:0]  b_mem_addr;
    logic [31:0] b_mem_rdata, b_data;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fft_frame_src #(.DATA_W(16), .LOGN(3), .ADDR_W(12)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
        .num_frames_i(nfr), .busy_o(busy), .done_o(done), .frame_cnt_o(frame_cnt),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .valid_o(valid), .data_o(data), .last_o(last), .ready_i(ready)
    );

    fft_frame_src #(.DATA_W(16), .LOGN(3), .ADDR_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .base_addr_i(b_base_addr),
        .num_frames_i(b_nfr), .busy_o(b_busy), .done_o(b_done), .frame_cnt_o(b_frame_cnt),
        .mem_req_o(b_mem_req), .mem_addr_o(b_mem_addr), .mem_rdata_i(b_mem_rdata),
        .valid_o(b_valid), .data_o(b_data), .last_o(b_last), .ready_i(b_ready)
    );

    function automatic logic [31:0] word12(input logic [11:0] a);
        return {16'h1000 + {4'h0, a}, 16'hF000 ^ {4'h0, a}};
    endfunction

    function automatic logic [31:0] word4(input logic [3:0] a);
        return {16'h2000 + {12'h0, a}, 16'h0F0F ^ {12'h0, a}};
    endfunction

    // Synchronous SRAM models: data one cycle after the request.
    always @(posedge clk) begin
        if (mem_req)   mem_rdata   <= word12(mem_addr);
        if (b_mem_req) b_mem_rdata <= word4(b_mem_addr);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (mem_req !== 1'b0)    begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req); end
        n_cmp++; if (valid !== 1'b0)      begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++; if (last !== 1'b0)       begin n_fail++; $display("FAIL reset_last got %b want 0", last); end
        n_cmp++; if (frame_cnt !== 8'd0)  begin n_fail++; $display("FAIL reset_fcnt got %0d want 0", frame_cnt); end
        n_cmp++; if (mem_addr !== 12'h0)  begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        n_cmp++; if (data !== 32'h0)      begin n_fail++; $display("FAIL reset_data got %h want 0", data); end
        n_cmp++; if (b_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_b_valid got %b want 0", b_valid); end
        n_cmp++; if (b_mem_addr !== 4'h0) begin n_fail++; $display("FAIL reset_b_addr got %h want 0", b_mem_addr); end
    endtask

    // One frame at full rate; optionally a second start mid-frame that must be ignored.
    task automatic test_basic_frame(input logic [11:0] base, input bit restart);
        logic [11:0] ea;
        next_cycle();
        start = 1'b1; base_addr = base; nfr = 8'd1; ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            start = restart && (k == 4);
            if (restart) begin base_addr = 12'h3F0; nfr = 8'd5; end
            #1;
            ea = base + 12'(k - 1);
            n_cmp++; if (mem_req !== (k <= 8)) begin n_fail++; $display("FAIL frame_req k=%0d got %b want %b", k, mem_req, (k <= 8)); end
            if (k <= 8) begin
                n_cmp++; if (mem_addr !== ea) begin n_fail++; $display("FAIL frame_addr k=%0d got %h want %h", k, mem_addr, ea); end
            end
            n_cmp++; if (valid !== (k >= 3 && k <= 10)) begin n_fail++; $display("FAIL frame_valid k=%0d got %b", k, valid); end
            if (k >= 3 && k <= 10) begin
                n_cmp++; if (data !== word12(base + 12'(k - 3))) begin n_fail++; $display("FAIL frame_data k=%0d got %h want %h", k, data, word12(base + 12'(k - 3))); end
                n_cmp++; if (last !== (k == 10)) begin n_fail++; $display("FAIL frame_last k=%0d got %b want %b", k, last, (k == 10)); end
            end
            n_cmp++; if (done !== (k == 11)) begin n_fail++; $display("FAIL frame_done k=%0d got %b want %b", k, done, (k == 11)); end
            n_cmp++; if (busy !== (k <= 10)) begin n_fail++; $display("FAIL frame_busy k=%0d got %b want %b", k, busy, (k <= 10)); end
            if (k >= 11) begin
                n_cmp++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL frame_fcnt k=%0d got %0d want 1", k, frame_cnt); end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_ready_toggle();
        int n = 0, issued = 0, popped = 0;
        bit got_done = 0, stall_prev = 0, prev_last = 0;
        logic [31:0] prev_data = '0;
        next_cycle();
        start = 1'b1; base_addr = 12'h100; nfr = 8'd1; ready = 1'b1;
        for (int cyc = 1; cyc <= 60 && !got_done; cyc++) begin
            next_cycle();
            start = 1'b0;
            ready = cyc[0];
            #1;
            if (stall_prev) begin
                n_cmp++; if (valid !== 1'b1 || data !== prev_data || last !== prev_last) begin
                    n_fail++; $display("FAIL stall_hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", cyc, valid, data, last, prev_data, prev_last);
                end
            end
            if (mem_req) issued++;
            if (valid && ready) begin
                n_cmp++; if (data !== word12(12'h100 + 12'(n))) begin n_fail++; $display("FAIL toggle_data n=%0d got %h want %h", n, data, word12(12'h100 + 12'(n))); end
                n_cmp++; if (last !== (n == 7)) begin n_fail++; $display("FAIL toggle_last n=%0d got %b want %b", n, last, (n == 7)); end
                n++; popped++;
            end
            n_cmp++; if (issued - popped > 2) begin n_fail++; $display("FAIL outstanding cyc=%0d got %0d want <=2", cyc, issued - popped); end
            stall_prev = valid && !ready;
            prev_data  = data;
            prev_last  = last;
            if (done) got_done = 1;
        end
        ready = 1'b1;
        n_cmp++; if (!got_done)        begin n_fail++; $display("FAIL toggle_done got 0 want 1 (timeout)"); end
        n_cmp++; if (n != 8)           begin n_fail++; $display("FAIL toggle_count got %0d want 8", n); end
        n_cmp++; if (issued != 8)      begin n_fail++; $display("FAIL toggle_reads got %0d want 8", issued); end
        n_cmp++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL toggle_fcnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_zero_frames();
        next_cycle();
        start = 1'b1; base_addr = 12'h555; nfr = 8'd0; ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            start = 1'b0;
            #1;
            n_cmp++; if (done !== (k == 1)) begin n_fail++; $display("FAIL zero_done k=%0d got %b want %b", k, done, (k == 1)); end
            n_cmp++; if (mem_req !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL zero_quiet k=%0d got req=%b valid=%b busy=%b want 0", k, mem_req, valid, busy);
            end
        end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL zero_fcnt got %0d want 0", frame_cnt); end
    endtask

    task automatic test_addr_wrap();
        logic [3:0] seq [16];
        int reqn = 0, n = 0;
        bit got_done = 0, pend = 0;
        logic [7:0] exp_fc = 8'd0;
        seq = '{4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3,
                4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
        next_cycle();
        b_start = 1'b1; b_base_addr = 4'hC; b_nfr = 8'd2; b_ready = 1'b1;
        for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
            next_cycle();
            b_start = 1'b0;
            #1;
            if (pend) begin
                n_cmp++; if (b_frame_cnt !== exp_fc) begin n_fail++; $display("FAIL wrap_fcnt got %0d want %0d", b_frame_cnt, exp_fc); end
                pend = 0;
            end
            if (b_mem_req) begin
                if (reqn < 16) begin
                    n_cmp++; if (b_mem_addr !== seq[reqn]) begin n_fail++; $display("FAIL wrap_addr r=%0d got %h want %h", reqn, b_mem_addr, seq[reqn]); end
                end
                reqn++;
            end
            if (b_valid && b_ready && n < 16) begin
                n_cmp++; if (b_data !== word4(seq[n])) begin n_fail++; $display("FAIL wrap_data n=%0d got %h want %h", n, b_data, word4(seq[n])); end
                n_cmp++; if (b_last !== (n == 7 || n == 15)) begin n_fail++; $display("FAIL wrap_last n=%0d got %b", n, b_last); end
                if (n == 7)  begin pend = 1; exp_fc = 8'd1; end
                if (n == 15) begin pend = 1; exp_fc = 8'd2; end
                n++;
            end
            if (b_done) got_done = 1;
        end
        n_cmp++; if (!got_done)            begin n_fail++; $display("FAIL wrap_done got 0 want 1 (timeout)"); end
        n_cmp++; if (reqn != 16)           begin n_fail++; $display("FAIL wrap_reqs got %0d want 16", reqn); end
        n_cmp++; if (n != 16)              begin n_fail++; $display("FAIL wrap_count got %0d want 16", n); end
        n_cmp++; if (b_frame_cnt !== 8'd2) begin n_fail++; $display("FAIL wrap_fcnt_end got %0d want 2", b_frame_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        next_cycle();
        start = 1'b1; base_addr = 12'h020; nfr = 8'd3; ready = 1'b1;
        repeat (6) begin
            next_cycle();
            start = 1'b0;
        end
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || valid !== 1'b0 || last !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ctrl got busy=%b done=%b req=%b valid=%b last=%b want 0", busy, done, mem_req, valid, last);
        end
        n_cmp++; if (frame_cnt !== 8'd0 || mem_addr !== 12'h0 || data !== 32'h0) begin
            n_fail++; $display("FAIL midrst_regs got fcnt=%0d addr=%h data=%h want 0", frame_cnt, mem_addr, data);
        end
        next_cycle();
        #1;
        n_cmp++; if (valid !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_discard got valid=%b req=%b busy=%b want 0", valid, mem_req, busy);
        end
        test_basic_frame(12'h080, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; nfr = '0; ready = 1'b1;
        b_start = 1'b0; b_base_addr = '0; b_nfr = '0; b_ready = 1'b1;
        repeat (3) next_cycle();
        test_reset();
        rst_n = 1'b1;
        test_basic_frame(12'h010, 1'b0);
        test_ready_toggle();
        test_zero_frames();
        test_addr_wrap();
        test_basic_frame(12'h040, 1'b1);
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
